// File: rtl/queue_pkg.sv
// Shared constants and helpers for the multi-channel register queue.
// Imported by queue_lane and queue_reg_mc.
package queue_pkg;

  localparam int MODE_FIFO = 0;
  localparam int MODE_LIFO = 1;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/queue_lane.sv
// One storage lane: DEPTH x WIDTH shift storage with registered read port.
// All strobes arrive pre-decoded and pre-qualified by the top level.
module queue_lane
  import queue_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int IDX_W = idx_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             do_clear,
  input  logic             do_push,
  input  logic             do_pop,
  input  logic             do_replace,
  input  logic             do_read,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [WIDTH-1:0] dout_q;

  // Entry 0 is the newest word; push moves everything up one slot.
  always_comb begin
    mem_d = mem_q;
    if (do_clear) begin
      for (int i = 0; i < DEPTH; i++) mem_d[i] = '0;
    end else if (do_push) begin
      for (int i = DEPTH - 1; i > 0; i--) mem_d[i] = mem_q[i-1];
      mem_d[0] = din_i;
    end else if (do_pop) begin
      for (int i = 0; i < DEPTH - 1; i++) mem_d[i] = mem_q[i+1];
      mem_d[DEPTH-1] = '0;
    end else if (do_replace) begin
      mem_d[0] = din_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      dout_q <= '0;
    end else begin
      mem_q <= mem_d;
      if (do_read) dout_q <= mem_q[rd_idx];
    end
  end

  assign dout_o = dout_q;

endmodule

// File: rtl/queue_reg_mc.sv
// Multi-channel FIFO/LIFO register queue with status and error pulses.
// Top level owns count, flags and strobes; lanes hold the data.
module queue_reg_mc
  import queue_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int CHANNELS = 2,
  parameter int MODE     = MODE_FIFO,
  parameter int CNT_W    = cnt_w(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ce,
  input  logic                      flush,
  input  logic                      push,
  input  logic                      pop,
  input  logic [CHANNELS*WIDTH-1:0] din,
  output logic [CHANNELS*WIDTH-1:0] dout,
  output logic                      dout_vld,
  output logic                      full,
  output logic                      empty,
  output logic [CNT_W-1:0]          count,
  output logic                      ovf,
  output logic                      udf
);

  localparam int IDX_W = idx_w(DEPTH);
  localparam bit IS_LIFO = (MODE == MODE_LIFO);

  logic [CNT_W-1:0] count_q, count_d;
  logic             vld_q, vld_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;

  logic             do_clear;
  logic             do_push;
  logic             do_pop;
  logic             do_replace;
  logic             do_read;
  logic [IDX_W-1:0] rd_idx;
  logic             is_full;
  logic             is_empty;

  assign is_full  = (count_q == CNT_W'(DEPTH));
  assign is_empty = (count_q == '0);

  // FIFO reads the oldest slot; guarded so the index stays in range.
  always_comb begin
    rd_idx = '0;
    if (!IS_LIFO && !is_empty) rd_idx = IDX_W'(count_q - CNT_W'(1));
  end

  always_comb begin
    count_d    = count_q;
    vld_d      = 1'b0;
    ovf_d      = 1'b0;
    udf_d      = 1'b0;
    do_clear   = 1'b0;
    do_push    = 1'b0;
    do_pop     = 1'b0;
    do_replace = 1'b0;
    do_read    = 1'b0;
    if (ce) begin
      if (flush) begin
        do_clear = 1'b1;
        count_d  = '0;
      end else if (push && !pop) begin
        if (is_full) begin
          ovf_d = 1'b1;
        end else begin
          do_push = 1'b1;
          count_d = count_q + CNT_W'(1);
        end
      end else if (pop && !push) begin
        if (is_empty) begin
          udf_d = 1'b1;
        end else begin
          do_read = 1'b1;
          do_pop  = IS_LIFO;
          vld_d   = 1'b1;
          count_d = count_q - CNT_W'(1);
        end
      end else if (push && pop) begin
        if (is_empty) begin
          do_push = 1'b1;
          udf_d   = 1'b1;
          count_d = CNT_W'(1);
        end else begin
          // Simultaneous access keeps occupancy constant.
          do_read    = 1'b1;
          vld_d      = 1'b1;
          do_push    = !IS_LIFO;
          do_replace = IS_LIFO;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
      vld_q   <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      vld_q   <= vld_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    queue_lane #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
    ) u_lane (
      .clk        (clk),
      .rst        (rst),
      .do_clear   (do_clear),
      .do_push    (do_push),
      .do_pop     (do_pop),
      .do_replace (do_replace),
      .do_read    (do_read),
      .rd_idx     (rd_idx),
      .din_i      (din[lane_lsb(c, WIDTH) +: WIDTH]),
      .dout_o     (dout[lane_lsb(c, WIDTH) +: WIDTH])
    );
  end

  assign dout_vld = vld_q;
  assign full     = is_full;
  assign empty    = is_empty;
  assign count    = count_q;
  assign ovf      = ovf_q;
  assign udf      = udf_q;

endmodule

// File: doc/queue_reg_mc.md
Name: queue_reg_mc

Overview:
Parametrised multi-channel register queue. It is the successor to the single-lane shift-register queue used for line/window buffering in the CNN datapath. CHANNELS lanes share one push/pop control and store WIDTH-bit words up to DEPTH deep. The queue runs in FIFO or LIFO order and adds full/empty/count status, overflow/underflow pulses, flush, and a registered output-valid strobe.

Parameters:
WIDTH, 8, bits per word per channel
DEPTH, 4, entries per channel (>=2)
CHANNELS, 2, parallel lanes sharing control
MODE, 0, 0 = FIFO (oldest out), 1 = LIFO (newest out)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  reset, synchronous, active-low
ce  in  1  clock enable; 0 freezes all state
flush  in  1  synchronous clear of contents/count
push  in  1  write din into all lanes
pop  in  1  read one word from all lanes
din  in  CHANNELS*WIDTH  lane c at bits [c*WIDTH +: WIDTH]
dout  out  CHANNELS*WIDTH  registered read data, same packing
dout_vld  out  1  one-cycle pulse, dout updated this cycle
full  out  1  count == DEPTH
empty  out  1  count == 0
count  out  CNT_W  entries held, CNT_W = clog2(DEPTH+1)
ovf  out  1  one-cycle pulse: push dropped
udf  out  1  one-cycle pulse: pop ignored

Behaviour:
- Reset (rst=0 at clk edge): storage=0, count=0, dout=0, dout_vld=0, ovf=0, udf=0; empty=1, full=0. Reset overrides ce.
- Priority: rst > ce=0 > flush > push/pop.
- ce=0: storage, count and dout hold; dout_vld, ovf and udf forced to 0.
- flush=1 (ce=1): count=0, storage zeroed, dout holds, pulses 0. Push/pop in the same cycle are ignored with no error pulse.
- Storage per lane: entry 0 is the newest. Push shifts entries up (entry i+1 <= entry i) and loads din into entry 0.
- Read latency is 1 cycle: pop sampled at edge N gives dout and dout_vld=1 after edge N. dout holds its value when there is no pop.
- FIFO read: dout <= entry[count-1]. No shift; count decrements.
- LIFO read: dout <= entry[0]. Entries shift down (entry i <= entry i+1, top entry <= 0); count decrements.
- full and empty are decoded combinationally from the count register.
- Push alone: if count<DEPTH, accept and count+1. If full, drop, state unchanged, ovf=1.
- Pop alone: if count>0, read as above. If empty, udf=1, dout_vld=0, dout holds.
- Push and pop together, count>0:
  - FIFO: dout <= entry[count-1], din shifts in, count unchanged. This also applies when full: the oldest word leaves, no ovf.
  - LIFO: dout <= entry[0] (pre-push value), entry 0 <= din, other entries unchanged, count unchanged.
- Push and pop together, count==0: push accepted (count=1), udf=1, dout_vld=0. There is no bypass.
- count never wraps; it is saturated by the full/empty rules above.
- Read index count-1 is always within 0..DEPTH-1 when a read is allowed. No out-of-range part-select is permitted.

Decomposition:
- Package queue_pkg:
  - MODE_FIFO=0, MODE_LIFO=1 constants
  - clog2-based CNT_W helper function
  - lane-slice helper for the [c*WIDTH +: WIDTH] packing
- Sub-module queue_lane, one instance per channel:
  - holds DEPTH x WIDTH storage
  - implements shift-up/shift-down/replace-top and the read mux
  - is driven by decoded control strobes (do_push, do_pop, do_replace, do_clear, rd_idx) from the top level
- The top level owns count, flags, error pulses and dout_vld.

Test Plan:
1. Reset then idle: hold rst=0 for 2 cycles -> dout=0, count=0, empty=1, full=0, dout_vld=0, ovf=udf=0.
2. FIFO, WIDTH=8, DEPTH=4, CHANNELS=2:
   - push 0x0201, 0x0403, 0x0605, 0x0807 -> full=1, count=4
   - 5th push 0x0A09 -> ovf pulse, count=4
   - 4 pops -> dout 0x0201, 0x0403, 0x0605, 0x0807, each one cycle after pop
3. FIFO full with push+pop of 0x1111 -> dout=0x0201, count=4, no ovf. Then 4 pops -> 0x0403, 0x0605, 0x0807, 0x1111.
4. LIFO (MODE=1):
   - push 0x0A0A, 0x0B0B, 0x0C0C, then pop -> 0x0C0C
   - push+pop with 0x0D0D -> dout 0x0B0B, count=2
   - 2 pops -> 0x0D0D, 0x0A0A
5. Empty pop, and empty push+pop of 0x3333 -> udf pulses, dout_vld=0, dout unchanged. After push+pop, count=1; the next pop returns 0x3333.
6. Control overrides:
   - ce=0 during push/pop -> no change, no pulses
   - flush at count=3 -> count=0, empty=1
   - rst=0 mid-stream -> all outputs at reset values on the next cycle
